utopia1_phy_rx: RTL

UTOPIA1_PHY_RX -- requirements
Module: utopia1_phy_rx

---
 rtl/utopia1_phy_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/utopia1_phy_rx.sv
// utopia1_phy_rx: Utopia level-1 PHY-side cell receiver with an NCELLS-deep
// cell buffer and a byte-wide handshaked output toward the switch core.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   atm_data/atm_soc/atm_en    cell byte, start-of-cell, active-low enable (ATM layer)
//   atm_clav                   registered cell-available flag
//   out_data/out_soc/out_valid buffered cell byte stream, oldest cell first
//   out_ready                  core accept; byte moves on out_valid & out_ready
//   drop                       one-cycle pulse when a partial or illegal cell is discarded
module utopia1_phy_rx #(
  parameter int unsigned NCELLS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] atm_data,
  input  logic       atm_soc,
  input  logic       atm_en,
  output logic       atm_clav,
  output logic [7:0] out_data,
  output logic       out_soc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       drop
);

  localparam int unsigned CELL_BYTES = 53;
  localparam int unsigned DEPTH      = NCELLS * CELL_BYTES;
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned SW         = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned CW         = $clog2(NCELLS + 1);
  localparam int unsigned IW         = 6;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [SW-1:0]   r_wr_slot;
  logic [SW-1:0]   r_rd_slot;
  logic [IW-1:0]   r_rd_idx;
  logic [CW-1:0]   r_reserved;
  logic [CW-1:0]   r_avail;
  logic            r_clav;
  logic [7:0]      r_out_data;
  logic            r_out_soc;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_drop;
  logic [7:0]      r_mem [DEPTH];

  logic            w_acc;
  logic            w_full;
  logic            w_we;
  logic [IW-1:0]   w_wr_idx;
  logic            w_start;
  logic            w_restart;
  logic            w_done;
  logic            w_viol;
  logic            w_free;
  logic            w_load;
  logic            w_fetch_last;
  logic [AW-1:0]   w_wr_addr;
  logic [AW-1:0]   w_rd_addr;
  logic [CW-1:0]   w_res_next;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    slot_inc = (s == SW'(NCELLS - 1)) ? '0 : s + SW'(1);
  endfunction

  assign w_acc  = ~atm_en;
  assign w_full = (r_reserved == CW'(NCELLS));

  // Receive-side decode of the accepted byte
  always_comb begin
    w_we      = 1'b0;
    w_wr_idx  = r_idx;
    w_start   = 1'b0;
    w_restart = 1'b0;
    w_done    = 1'b0;
    w_viol    = 1'b0;
    if (w_acc && !reset) begin
      case (r_state)
        S_IDLE: begin
          if (atm_soc) begin
            if (w_full) begin
              w_viol = 1'b1;
            end else begin
              w_we     = 1'b1;
              w_wr_idx = '0;
              w_start  = 1'b1;
            end
          end
        end
        S_RECV: begin
          w_we = 1'b1;
          if (atm_soc) begin
            // restart the same reserved slot; reservation count unchanged
            w_wr_idx  = '0;
            w_restart = 1'b1;
          end else begin
            w_done = (r_idx == IW'(CELL_BYTES - 1));
          end
        end
        default: ;
      endcase
    end
  end

  assign w_wr_addr    = AW'(r_wr_slot) * AW'(CELL_BYTES) + AW'(w_wr_idx);
  assign w_rd_addr    = AW'(r_rd_slot) * AW'(CELL_BYTES) + AW'(r_rd_idx);
  // a slot is released only when its last byte is handed to the core
  assign w_free       = r_out_valid & out_ready & r_out_last;
  // one-entry output register is refilled when empty or being consumed
  assign w_load       = (r_avail != '0) & (~r_out_valid | out_ready);
  assign w_fetch_last = (r_rd_idx == IW'(CELL_BYTES - 1));
  assign w_res_next   = r_reserved + CW'(w_start) - CW'(w_free);

  // Cell storage, not reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_addr] <= atm_data;
  end

  // Receive FSM, slot accounting and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_rd_idx    <= '0;
      r_reserved  <= '0;
      r_avail     <= '0;
      r_clav      <= 1'b1;
      r_out_data  <= 8'h00;
      r_out_soc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_restart | w_viol;

      if (w_start || w_restart) begin
        r_idx   <= IW'(1);
        r_state <= S_RECV;
      end else if (w_we) begin
        if (w_done) begin
          r_idx     <= '0;
          r_state   <= S_IDLE;
          r_wr_slot <= slot_inc(r_wr_slot);
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end

      r_reserved <= w_res_next;
      // flag follows the reservation count one clock later
      r_clav     <= (r_reserved < CW'(NCELLS));
      r_avail    <= r_avail + CW'(w_done) - CW'(w_load & w_fetch_last);

      if (w_load) begin
        r_out_data  <= r_mem[w_rd_addr];
        r_out_soc   <= (r_rd_idx == '0);
        r_out_last  <= w_fetch_last;
        r_out_valid <= 1'b1;
        if (w_fetch_last) begin
          r_rd_idx  <= '0;
          r_rd_slot <= slot_inc(r_rd_slot);
        end else begin
          r_rd_idx <= r_rd_idx + IW'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign atm_clav  = r_clav;
  assign out_data  = r_out_data;
  assign out_soc   = r_out_soc;
  assign out_valid = r_out_valid;
  assign drop      = r_drop;

endmodule
